// File: rtl/game_timer_pkg.sv
// Shared defaults and FSM state encoding for the game countdown timer.
package game_timer_pkg;

    localparam int unsigned DEFAULT_CLK_HZ       = 100_000_000;
    localparam int unsigned DEFAULT_GAME_SECONDS = 30;
    localparam int unsigned DEFAULT_WARN_SECONDS = 5;

    typedef enum logic [1:0] {
        ST_LOADED  = 2'b00,
        ST_RUN     = 2'b01,
        ST_EXPIRED = 2'b10
    } state_t;

endpackage

// File: rtl/game_timer_tick_gen.sv
// Prescaler: counts enabled cycles and flags the cycle on which it wraps at CLK_HZ-1.
module tick_gen
    import game_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned    CW   = $clog2(CLK_HZ);
    localparam logic [CW-1:0]  LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] r_cnt;

    // Combinational so the owner can register its decrement on the wrap edge.
    assign tick = enable && !clear && (r_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (enable)
            r_cnt <= tick ? '0 : r_cnt + CW'(1);
    end

endmodule

// File: rtl/game_timer.sv
// Game countdown: LOADED/RUN/EXPIRED FSM driving a two-digit BCD seconds counter.
module game_timer
    import game_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ       = DEFAULT_CLK_HZ,
    parameter int unsigned GAME_SECONDS = DEFAULT_GAME_SECONDS,
    parameter int unsigned WARN_SECONDS = DEFAULT_WARN_SECONDS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_active,
    input  logic       sys_reset,
    output logic       time_up,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       warn,
    output logic       sec_tick
);

    localparam logic [3:0] RELOAD_TENS = 4'(GAME_SECONDS / 10);
    localparam logic [3:0] RELOAD_ONES = 4'(GAME_SECONDS % 10);
    localparam logic [6:0] WARN_VAL    = 7'(WARN_SECONDS);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_tens, r_ones, w_tens_nxt, w_ones_nxt;
    logic       r_time_up, w_time_up_nxt;
    logic       r_warn, w_warn_nxt;
    logic       r_sec_tick, w_sec_tick_nxt;
    logic       w_tick;
    logic [6:0] w_val_nxt;

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (sys_reset),
        .enable ((r_state == ST_RUN) && game_active),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_LOADED;
            r_tens     <= RELOAD_TENS;
            r_ones     <= RELOAD_ONES;
            r_time_up  <= 1'b0;
            r_warn     <= 1'b0;
            r_sec_tick <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tens     <= w_tens_nxt;
            r_ones     <= w_ones_nxt;
            r_time_up  <= w_time_up_nxt;
            r_warn     <= w_warn_nxt;
            r_sec_tick <= w_sec_tick_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_tens_nxt     = r_tens;
        w_ones_nxt     = r_ones;
        w_time_up_nxt  = r_time_up;
        w_sec_tick_nxt = 1'b0;
        if (sys_reset) begin
            w_state_nxt   = ST_LOADED;
            w_tens_nxt    = RELOAD_TENS;
            w_ones_nxt    = RELOAD_ONES;
            w_time_up_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_LOADED: if (game_active) w_state_nxt = ST_RUN;
                ST_RUN: if (w_tick) begin
                    w_sec_tick_nxt = 1'b1;
                    if (r_tens == 4'd0 && r_ones == 4'd1) begin
                        w_state_nxt   = ST_EXPIRED;
                        w_ones_nxt    = 4'd0;
                        w_time_up_nxt = 1'b1;
                    end else if (r_ones == 4'd0) begin
                        w_ones_nxt = 4'd9;
                        w_tens_nxt = r_tens - 4'd1;
                    end else begin
                        w_ones_nxt = r_ones - 4'd1;
                    end
                end
                ST_EXPIRED: begin
                    w_tens_nxt    = 4'd0;
                    w_ones_nxt    = 4'd0;
                    w_time_up_nxt = 1'b1;
                end
                default: w_state_nxt = ST_LOADED;
            endcase
        end
    end

    // warn is registered from the next-state view so it lines up with the digits it describes.
    assign w_val_nxt  = 7'(w_tens_nxt) * 7'd10 + 7'(w_ones_nxt);
    assign w_warn_nxt = (w_state_nxt == ST_RUN) && (w_val_nxt != 7'd0) && (w_val_nxt <= WARN_VAL);

    assign time_up  = r_time_up;
    assign sec_tens = r_tens;
    assign sec_ones = r_ones;
    assign warn     = r_warn;
    assign sec_tick = r_sec_tick;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer with a seconds-elapsed reference model checked every cycle.
module tb_game_timer;

    localparam int HZ   = 4;
    localparam int GAME = 12;
    localparam int WARN = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       game_active = 1'b0;
    logic       sys_reset = 1'b0;
    logic       time_up, warn, sec_tick;
    logic [3:0] sec_tens, sec_ones;

    int total = 0;
    int bad   = 0;

    game_timer #(.CLK_HZ(HZ), .GAME_SECONDS(GAME), .WARN_SECONDS(WARN)) dut (
        .clk         (clk),
        .reset       (reset),
        .game_active (game_active),
        .sys_reset   (sys_reset),
        .time_up     (time_up),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .warn        (warn),
        .sec_tick    (sec_tick)
    );

    always #5 clk = ~clk;

    // Model: mode 0=loaded 1=running 2=expired; elapsed counts active running cycles.
    int m_mode    = 0;
    int m_elapsed = 0;
    bit m_tick    = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_elapsed = 0; m_tick = 0;
        end else begin
            m_tick = 0;
            if (sys_reset) begin
                m_mode = 0; m_elapsed = 0;
            end else if (m_mode == 0) begin
                if (game_active) m_mode = 1;
            end else if (m_mode == 1 && game_active) begin
                m_elapsed++;
                if (m_elapsed % HZ == 0) m_tick = 1;
                if (m_elapsed == GAME * HZ) m_mode = 2;
            end
        end
    end

    function automatic int m_rem();
        return (m_mode == 2) ? 0 : GAME - m_elapsed / HZ;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int r;
        r = m_rem();
        chk("cycle", {time_up, sec_tens, sec_ones, warn, sec_tick},
            {(m_mode == 2), 4'(r / 10), 4'(r % 10),
             (m_mode == 1 && r >= 1 && r <= WARN), m_tick});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k, first_tick, up_at, nticks;
        cyc(3);
        reset = 1'b0;
        cyc(2);
        chk("rst_digits", {sec_tens, sec_ones}, 8'h12);
        chk("rst_up_warn", {time_up, warn, sec_tick}, 0);

        // Full countdown with game_active held high.
        sys_reset = 1'b1; cyc(1);
        sys_reset = 1'b0; game_active = 1'b1; cyc(1);
        k = 0; first_tick = 0; up_at = 0; nticks = 0;
        while (up_at == 0 && k < 60) begin
            cyc(1); k++;
            if (sec_tick) begin
                nticks++;
                if (first_tick == 0) first_tick = k;
            end
            if (k == 4)  chk("d11", {sec_tens, sec_ones}, 8'h11);
            if (k == 8)  chk("d10", {sec_tens, sec_ones}, 8'h10);
            if (k == 12) chk("d09", {sec_tens, sec_ones}, 8'h09);
            if (k == 27) chk("warn_at06", warn, 0);
            if (k == 28) chk("warn_at05", warn, 1);
            if (time_up) up_at = k;
        end
        chk("first_tick", first_tick, 4);
        chk("time_up_at", up_at, 48);
        chk("up_digits", {sec_tens, sec_ones}, 0);
        chk("tick_count", nticks, 12);

        // Expired ignores game_active until sys_reset.
        for (int i = 0; i < 6; i++) begin
            game_active = ~game_active; cyc(1);
        end
        chk("exp_hold", {time_up, sec_tens, sec_ones}, 9'h100);
        game_active = 1'b0; sys_reset = 1'b1; cyc(1);
        chk("exp_reload", {time_up, sec_tens, sec_ones}, 9'h012);
        sys_reset = 1'b0; cyc(1);

        // Pause at 06 with the prescaler two cycles in.
        game_active = 1'b1; cyc(1);
        cyc(26);
        chk("pause_d06", {sec_tens, sec_ones}, 8'h06);
        game_active = 1'b0;
        nticks = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (sec_tick) nticks++;
        end
        chk("pause_ticks", nticks, 0);
        chk("pause_hold", {sec_tens, sec_ones, warn}, 9'h0C);
        game_active = 1'b1;
        k = 0;
        while (!sec_tick && k < 10) begin
            cyc(1); k++;
        end
        chk("resume_wait", k, 2);
        chk("resume_d05", {sec_tens, sec_ones, warn}, 9'h0B);

        // sys_reset wins over game_active at 07.
        game_active = 1'b0; sys_reset = 1'b1; cyc(1);
        sys_reset = 1'b0; game_active = 1'b1; cyc(1);
        cyc(21);
        chk("pre_d07", {sec_tens, sec_ones}, 8'h07);
        sys_reset = 1'b1; cyc(1);
        chk("both_reload", {time_up, sec_tens, sec_ones, warn, sec_tick}, 11'h048);
        cyc(2);
        chk("both_hold", {sec_tens, sec_ones}, 8'h12);
        sys_reset = 1'b0; game_active = 1'b0; cyc(1);

        // Async reset mid-cycle at 03.
        game_active = 1'b1; cyc(1);
        cyc(38);
        chk("pre_d03", {sec_tens, sec_ones, warn}, 9'h07);
        #2 reset = 1'b1;
        #1 chk("async_rst", {time_up, sec_tens, sec_ones, warn, sec_tick}, 11'h048);
        game_active = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(3);
        chk("post_rst", {sec_tens, sec_ones, time_up}, 9'h024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
